// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx (and later uart_tx).
//   - 8N1 frame constants
//   - legal range of the ClksPerBit parameter
//   - receive FSM state encoding
package uart_pkg;

  localparam int unsigned DataBits      = 8;
  localparam int unsigned StopBits      = 1;
  localparam int unsigned MinClksPerBit = 4;
  localparam int unsigned MaxClksPerBit = 65535;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs. Both stages reset to 1 so an
// idle-high serial line never shows a spurious low edge coming out of reset.
// Ports:
//   clk_i    - destination clock
//   reset_ni - synchronous active-low reset
//   d_i      - asynchronous input bits
//   q_o      - synchronized bits, two cycles after d_i
module uart_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Ports:
//   clk_i       - clock, all logic on the rising edge
//   reset_ni    - synchronous active-low reset
//   rx_i        - asynchronous serial line, idle high
//   ready_i     - downstream accepts data_o when valid_o & ready_i
//   valid_o     - data_o holds an unaccepted byte
//   data_o      - received byte (LSB first on the line)
//   frame_err_o - one-cycle pulse: stop bit sampled low
//   overrun_o   - one-cycle pulse: completed byte dropped, buffer full
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned ClksPerBit = 868
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                rx_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [DataBits-1:0] data_o,
  output logic                frame_err_o,
  output logic                overrun_o
);

  if (ClksPerBit < MinClksPerBit || ClksPerBit > MaxClksPerBit) begin : gen_bad_clks
    $error("uart_rx: ClksPerBit must be within 4..65535");
  end
  if (StopBits != 1) begin : gen_bad_stop
    $error("uart_rx: only a single stop bit is supported");
  end

  localparam int unsigned CntW = $clog2(ClksPerBit);
  // Counter values at which the half-bit and full-bit intervals expire.
  localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(ClksPerBit - 1);
  localparam logic [2:0]      LastIdx  = 3'(DataBits - 1);

  logic rx_s;

  uart_sync #(
    .Width(1)
  ) u_sync (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  uart_rx_state_e      state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          idx_q;
  logic [DataBits-1:0] shift_q;
  logic                valid_q;
  logic [DataBits-1:0] data_q;
  logic                frame_err_q;
  logic                overrun_q;

  logic accept;
  logic half_done;
  logic full_done;

  assign accept    = valid_q & ready_i;
  assign half_done = (cnt_q == HalfLast);
  assign full_done = (cnt_q == FullLast);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A delivery in the Stop state below overrides this clear.
      if (accept) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            state_q <= StStart;
          end
        end

        StStart: begin
          if (half_done) begin
            cnt_q <= '0;
            if (rx_s) begin
              // Line went back high before mid start bit: treat as noise.
              state_q <= StIdle;
            end else begin
              idx_q   <= '0;
              state_q <= StData;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (full_done) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == LastIdx) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StStop: begin
          if (full_done) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
              if (!valid_q || accept) begin
                valid_q <= 1'b1;
                data_q  <= shift_q;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StBreak: begin
          // Do not hunt for start bits until the line has returned high.
          if (rx_s) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned Cpb = 16;

  logic       clk_i    = 1'b0;
  logic       reset_ni = 1'b0;
  logic       rx_i     = 1'b1;
  logic       ready_i  = 1'b0;
  logic       valid_o;
  logic [7:0] data_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(
    .ClksPerBit(Cpb)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .rx_i       (rx_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  bit          checking = 1'b0;
  bit          rand_ready = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a sequential description of frame reception. Outputs
  // m_* hold the values the DUT must show after each rising edge.
  // ---------------------------------------------------------------------------
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_vbefore, m_acc;
  logic       line_d1 = 1'b1;  // line value delayed by one / two cycles
  logic       line_d2 = 1'b1;

  // Advance one clock edge; s is the line as seen by the receiver at that edge.
  task automatic tick(output logic s, output bit ab);
    @(posedge clk_i);
    s         = line_d2;
    ab        = 1'b0;
    m_ferr    = 1'b0;
    m_ovr     = 1'b0;
    m_vbefore = m_valid;
    m_acc     = m_valid && ready_i;
    if (!reset_ni) begin
      line_d1 = 1'b1;
      line_d2 = 1'b1;
      m_valid = 1'b0;
      m_data  = 8'h00;
      ab      = 1'b1;
    end else begin
      line_d2 = line_d1;
      line_d1 = rx_i;
      if (m_acc) m_valid = 1'b0;
    end
  endtask

  task automatic deliver(input logic [7:0] b);
    if (!m_vbefore || m_acc) begin
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  // Entered right after the edge at which an idle receiver saw the line low.
  task automatic rx_frame();
    logic       s;
    bit         ab;
    logic [7:0] b;
    s = 1'b1;
    b = 8'h00;
    for (int i = 0; i < Cpb / 2; i++) begin
      tick(s, ab);
      if (ab) return;
    end
    if (s) return;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < Cpb; i++) begin
        tick(s, ab);
        if (ab) return;
      end
      b[k] = s;
    end
    for (int i = 0; i < Cpb; i++) begin
      tick(s, ab);
      if (ab) return;
    end
    if (s) begin
      deliver(b);
      return;
    end
    m_ferr = 1'b1;
    do begin
      tick(s, ab);
      if (ab) return;
    end while (!s);
  endtask

  initial begin
    logic s;
    bit   ab;
    forever begin
      tick(s, ab);
      if (!ab && !s) rx_frame();
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and event monitor, just after the falling edge.
  // ---------------------------------------------------------------------------
  logic        prev_valid = 1'b0;
  int unsigned valid_rise_cyc = 0;
  int          n_ferr = 0;
  int          n_ovr  = 0;
  logic [7:0]  acc_q[$];

  initial forever begin
    @(negedge clk_i);
    #1;
    if (checking) begin
      check("valid_o", 32'(valid_o), 32'(m_valid));
      check("data_o", 32'(data_o), 32'(m_data));
      check("frame_err_o", 32'(frame_err_o), 32'(m_ferr));
      check("overrun_o", 32'(overrun_o), 32'(m_ovr));
    end
    if (valid_o === 1'b1 && prev_valid !== 1'b1) valid_rise_cyc = cyc;
    prev_valid = valid_o;
    if (valid_o === 1'b1 && ready_i === 1'b1) acc_q.push_back(data_o);
    if (frame_err_o === 1'b1) n_ferr++;
    if (overrun_o === 1'b1) n_ovr++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change only right after a falling edge.
  // ---------------------------------------------------------------------------
  int unsigned fall_cyc = 0;

  task automatic step();
    @(negedge clk_i);
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves rx_i at the stop-bit value. rst_bit >= 0 pulses reset in the
  // middle of that data bit and abandons the frame with the line idle.
  task automatic send(input logic [7:0] b, input logic stop, input int rst_bit);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      if (i == 0) fall_cyc = cyc;
      for (int c = 0; c < Cpb; c++) begin
        if (rst_bit >= 0 && i == rst_bit + 1 && c == Cpb / 2) begin
          reset_ni = 1'b0;
          rx_i     = 1'b1;
          step();
          reset_ni = 1'b1;
          return;
        end
        step();
      end
    end
  endtask

  task automatic clear_log();
    acc_q.delete();
    n_ferr = 0;
    n_ovr  = 0;
  endtask

  initial begin
    int kind;
    int hold_cnt;

    step();
    idle(3);
    reset_ni = 1'b1;
    checking = 1'b1;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset data_o", 32'(data_o), 32'h00);
    check("reset frame_err_o", 32'(frame_err_o), 32'd0);
    check("reset overrun_o", 32'(overrun_o), 32'd0);
    idle(5);

    // Single byte, latency from rx_i falling edge.
    ready_i = 1'b1;
    clear_log();
    valid_rise_cyc = 0;
    send(8'hA5, 1'b1, -1);
    idle(20);
    check("single latency", 32'(valid_rise_cyc - fall_cyc), 32'd155);
    check("single count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("single data", 32'(acc_q[0]), 32'hA5);
    check("single errs", 32'(n_ferr + n_ovr), 32'd0);

    // Hold with ready low.
    ready_i = 1'b0;
    clear_log();
    send(8'h3C, 1'b1, -1);
    idle(5);
    hold_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (valid_o === 1'b1 && data_o === 8'h3C) hold_cnt++;
      step();
    end
    check("hold cycles", 32'(hold_cnt), 32'd100);
    ready_i = 1'b1;
    step();
    check("hold drop", 32'(valid_o), 32'd0);
    check("hold accepted", 32'(acc_q.size()), 32'd1);
    idle(5);

    // Glitch on the line.
    clear_log();
    rx_i = 1'b0;
    idle(5);
    rx_i = 1'b1;
    idle(30);
    check("glitch no byte", 32'(acc_q.size()), 32'd0);
    check("glitch no ferr", 32'(n_ferr), 32'd0);
    send(8'h81, 1'b1, -1);
    idle(20);
    check("after glitch count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("after glitch data", 32'(acc_q[0]), 32'h81);

    // Framing error followed by a break.
    clear_log();
    send(8'h55, 1'b0, -1);
    idle(60);
    rx_i = 1'b1;
    idle(20);
    check("frame err pulses", 32'(n_ferr), 32'd1);
    check("frame no byte", 32'(acc_q.size()), 32'd0);
    send(8'h0F, 1'b1, -1);
    idle(20);
    check("after break count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("after break data", 32'(acc_q[0]), 32'h0F);

    // Overrun with ready low, then back-to-back delivery with ready high.
    clear_log();
    ready_i = 1'b0;
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    idle(20);
    check("overrun pulses", 32'(n_ovr), 32'd1);
    check("overrun valid", 32'(valid_o), 32'd1);
    check("overrun data kept", 32'(data_o), 32'h11);
    ready_i = 1'b1;
    step();
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    idle(20);
    check("b2b count", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      check("b2b first", 32'(acc_q[1]), 32'h00);
      check("b2b second", 32'(acc_q[2]), 32'hFF);
    end

    // Reset in the middle of data bit 3.
    clear_log();
    send(8'h77, 1'b1, 3);
    check("midreset valid_o", 32'(valid_o), 32'd0);
    check("midreset data_o", 32'(data_o), 32'h00);
    idle(200);
    check("midreset no byte", 32'(acc_q.size()), 32'd0);
    send(8'h99, 1'b1, -1);
    idle(20);
    check("after reset count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("after reset data", 32'(acc_q[0]), 32'h99);

    // Randomized traffic; the model compare covers every cycle.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        rx_i = 1'b0;
        idle(int'($urandom_range(1, Cpb)));
        rx_i = 1'b1;
      end else if (kind == 1) begin
        send(8'($urandom), 1'b0, -1);
        idle(int'($urandom_range(0, 40)));
        rx_i = 1'b1;
      end else if (kind == 2) begin
        send(8'($urandom), 1'b1, int'($urandom_range(0, 8)));
      end else begin
        send(8'($urandom), 1'b1, -1);
      end
      idle(int'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    rx_i       = 1'b1;
    idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented 8N1 UART receiver that turns the asynchronous serial line into a valid/ready byte stream. It sits directly upstream of the ALU command parser, and its `valid_o`/`data_o`/`ready_i` connect straight to the parser's byte input. It synchronizes the line, qualifies start bits, samples mid-bit, checks the stop bit, and holds each received byte in a one-entry output buffer until it is accepted. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- `ClksPerBit`, default 868: clock cycles per bit (100 MHz / 115200 baud). Legal range 4..65535; elaboration fails outside it.

Ports:
- `clk_i`  input  1  single clock; all logic on its rising edge.
- `reset_ni`  input  1  reset, synchronous, active-low.
- `rx_i`  input  1  asynchronous serial line; idle high.
- `ready_i`  input  1  downstream accepts the byte when `valid_o & ready_i`.
- `valid_o`  output  1  `data_o` holds an unaccepted byte.
- `data_o`  output  8  received byte, LSB first on the line.
- `frame_err_o`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  output  1  one-cycle pulse: a completed byte was dropped because the buffer was full.

## Operation
- `rx_i` passes through a 2-flop synchronizer; `rx_s` is the synchronized value. Synchronizer flops reset to 1.
- Bit counter width is `$clog2(ClksPerBit)`; the bit index is 3 bits.
- States:
  - Idle: waits for `rx_s==0`, then clears the cycle counter and moves to Start.
  - Start: after `ClksPerBit/2` cycles (floor), samples `rx_s`. If 1, it is a glitch: return to Idle with no pulse. If 0, clear the counter and go to Data with bit index 0.
  - Data: every `ClksPerBit` cycles, sample `rx_s` into shift-register bit `idx` (LSB first). After bit 7, go to Stop.
  - Stop: after `ClksPerBit` cycles, sample. If 1, deliver the byte and go to Idle. If 0, pulse `frame_err_o`, discard the byte, and go to Break.
  - Break: wait for `rx_s==1`, then go to Idle. Starts are not hunted while the line stays low.
- Delivery:
  - Buffer empty, or being accepted this cycle (`valid_o & ready_i`): load `data_o`, and `valid_o` is 1 next cycle.
  - Buffer full and not being accepted: drop the new byte, pulse `overrun_o`, and leave `data_o`/`valid_o` unchanged.
- Buffer:
  - `valid_o` clears on `valid_o & ready_i` unless a new byte loads in the same cycle.
  - `data_o` is stable while `valid_o` is high and unaccepted.
  - `ready_i` has no effect on the receive FSM.
- All outputs are registered.

## Timing
- Reset values: `valid_o=0`, `data_o=8'h00`, `frame_err_o=0`, `overrun_o=0`, state Idle.
- Reset during a frame aborts the frame silently; the buffer empties.
- Let t0 be the cycle in which Idle sees `rx_s==0`.
  - Start sample: t0+`ClksPerBit/2`.
  - Data bit k sample: t0+`ClksPerBit/2`+(k+1)·`ClksPerBit`.
  - Stop sample: t0+`ClksPerBit/2`+9·`ClksPerBit`.
- `valid_o`, `frame_err_o` and `overrun_o` assert in the cycle after the stop sample.
- The `rx_i`→`rx_s` latency is 2 cycles.
- After a good stop sample, Idle is re-entered the next cycle, so a start bit immediately following the stop bit is caught. Back-to-back frames lose no bytes when `ready_i=1`.
- `ready_i` held low forever: the first byte is kept and every later byte produces an `overrun_o` pulse.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_e` enum (Idle, Start, Data, Stop, Break).
  - 8N1 frame constants (data bits = 8, stop bits = 1).
  - The same package later serves `uart_tx`.
- Sub-module `uart_sync`: parameterized-width 2-flop synchronizer with reset value 1. It is reused by `uart_tx` and top-level inputs.
- Counter, shift register, FSM and output buffer are implemented inline in `uart_rx`.

## Test plan
(`ClksPerBit=16` in all scenarios.)
- Single byte: send 0xA5 with `ready_i=1`. `valid_o` pulses one cycle with `data_o=0xA5`, 2+8+144+1 cycles after the `rx_i` falling edge; no error pulses.
- Hold: `ready_i=0`, send 0x3C. `valid_o` stays 1 and `data_o` stays 0x3C for 100 cycles. Raise `ready_i`; `valid_o` drops the next cycle.
- Glitch: drive `rx_i` low for 5 cycles, then high. No `valid_o`, no `frame_err_o`, FSM back in Idle. A following 0x81 is received correctly.
- Framing/break: send 0x55 with stop bit 0, then hold `rx_i` low for 60 cycles, then high. Expect exactly one `frame_err_o` pulse and no `valid_o`. A subsequent 0x0F is received.
- Overrun: `ready_i=0`, send 0x11 then 0x22 back-to-back. Expect one `overrun_o` pulse and `data_o=0x11` retained. With `ready_i=1`, 0x00 and 0xFF sent back-to-back are both delivered.
- Reset mid-frame: drop `reset_ni` for 1 cycle at data bit 3 of 0x77. All outputs return to reset values and no byte is delivered. Next frame 0x99 is received.
